display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 36 +++
 rtl/scan_slot_timer.sv | 52 +++++
 rtl/display_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants, scan state type and anode lookup
// for the scoreboard 7-segment display blocks.
package display_pkg;

  // Active-low common-anode digit enables.
  localparam logic [3:0] AN_D0  = 4'b0111;
  localparam logic [3:0] AN_D1  = 4'b1011;
  localparam logic [3:0] AN_D2  = 4'b1101;
  localparam logic [3:0] AN_D3  = 4'b1110;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Nibble the segment decoder renders as all segments off.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_e;

  function automatic logic [3:0] an_code(
    input logic [1:0] idx
  );
    logic [3:0] code;
    code = AN_OFF;
    unique case (idx)
      2'd0: code = AN_D0;
      2'd1: code = AN_D1;
      2'd2: code = AN_D2;
      2'd3: code = AN_D3;
      default: code = AN_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: per-slot cycle counter with strobes marking the
// end of the dark lead-in and the end of the whole slot.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear, holds the count at zero
//   blank_end_o count is on the last dark cycle of the slot
//   slot_end_o  count is on the last cycle of the slot
module scan_slot_timer #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic blank_end_o,
  output logic slot_end_o
);

  localparam int CW =
    (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST =
    CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign blank_end_o = (cnt_q == BLANK_LAST);
  assign slot_end_o  = (cnt_q == SLOT_LAST);

  // The count wraps on its own at slot end so the
  // controller only has to steer the state.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || slot_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed refresh of the 4-digit
// scoreboard, one digit per slot, with dark gaps and frame snapshots.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   enable     1 = scanning, 0 = display dark
//   lz_blank   suppress a zero tens digit for either team
//   score_a    team A score {tens, units} in BCD
//   score_b    team B score {tens, units} in BCD
//   anodo      active-low digit enables
//   bcd        nibble for the lit digit, 4'hF = blank
//   digit_idx  current slot index
//   frame_done one-cycle pulse after the digit-3 slot
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       lz_blank,
  input  logic [7:0] score_a,
  input  logic [7:0] score_b,
  output logic [3:0] anodo,
  output logic [3:0] bcd,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  scan_state_e state_q;
  scan_state_e state_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic [7:0]  snap_a_q;
  logic [7:0]  snap_a_d;
  logic [7:0]  snap_b_q;
  logic [7:0]  snap_b_d;
  logic [3:0]  anodo_q;
  logic [3:0]  anodo_d;
  logic [3:0]  bcd_q;
  logic [3:0]  bcd_d;
  logic        fd_q;
  logic        fd_d;

  logic        timer_clr;
  logic        blank_end;
  logic        slot_end;
  logic        snap_load;
  logic [3:0]  nib;
  logic        lz_hit;
  logic        bad_bcd;
  logic        lit;

  assign timer_clr = !enable || (state_q == IDLE);

  scan_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .clr_i       (timer_clr),
    .blank_end_o (blank_end),
    .slot_end_o  (slot_end)
  );

  // Sequencing. Dropping enable wins over everything and
  // never produces a frame_done pulse.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_load = 1'b0;
    fd_d      = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = BLANK;
          idx_d     = 2'd0;
          snap_load = 1'b1;
        end
        BLANK: begin
          if (blank_end) begin
            state_d = ON;
          end
        end
        ON: begin
          if (slot_end) begin
            state_d = BLANK;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              fd_d      = 1'b1;
              snap_load = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Scores are sampled only at frame boundaries so a
  // frame is never a mix of old and new digits.
  always_comb begin
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    if (snap_load) begin
      snap_a_d = score_a;
      snap_b_d = score_b;
    end
  end

  // Outputs are computed from next-state values so the
  // registered anode and nibble line up with the state
  // held in the same cycle and always change together.
  always_comb begin
    nib = BCD_BLANK;
    unique case (idx_d)
      2'd0: nib = snap_a_d[7:4];
      2'd1: nib = snap_a_d[3:0];
      2'd2: nib = snap_b_d[7:4];
      2'd3: nib = snap_b_d[3:0];
      default: nib = BCD_BLANK;
    endcase
  end

  assign lit     = (state_d == ON);
  assign bad_bcd = (nib > 4'd9);
  // Tens digits sit on even indices.
  assign lz_hit  = lz_blank && !idx_d[0]
                && (nib == 4'd0);

  always_comb begin
    anodo_d = AN_OFF;
    bcd_d   = BCD_BLANK;
    if (lit && !lz_hit) begin
      anodo_d = an_code(idx_d);
      if (!bad_bcd) begin
        bcd_d = nib;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      snap_a_q <= 8'hFF;
      snap_b_q <= 8'hFF;
      anodo_q  <= AN_OFF;
      bcd_q    <= BCD_BLANK;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      anodo_q  <= anodo_d;
      bcd_q    <= bcd_d;
      fd_q     <= fd_d;
    end
  end

  assign anodo      = anodo_q;
  assign bcd        = bcd_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench for display_scan_ctrl
// with 8-cycle slots and 2 dark cycles per slot.
module tb_display_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       lz_blank;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic [3:0] anodo;
  logic [3:0] bcd;
  logic [1:0] digit_idx;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .score_a    (score_a),
    .score_b    (score_b),
    .anodo      (anodo),
    .bcd        (bcd),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_anodo"}, 8'(anodo), 8'hF);
    chk({tag, "_bcd"}, 8'(bcd), 8'hF);
    chk({tag, "_idx"}, 8'(digit_idx), 8'h0);
    chk({tag, "_fd"}, 8'(frame_done), 8'h0);
  endtask

  // Called on the first cycle of a slot; returns on the
  // first cycle of the following slot.
  task automatic slot(
    input logic [1:0] idx,
    input logic [3:0] an,
    input logic [3:0] b,
    input logic       fd
  );
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("idx_s%0d_c%0d", idx, c),
          8'(digit_idx), 8'(idx));
      chk($sformatf("fd_s%0d_c%0d", idx, c),
          8'(frame_done), (c == 0) ? 8'(fd) : 8'h0);
      if (c < 2) begin
        chk($sformatf("dark_s%0d_c%0d", idx, c),
            8'(anodo), 8'hF);
      end else begin
        chk($sformatf("anodo_s%0d_c%0d", idx, c),
            8'(anodo), 8'(an));
        chk($sformatf("bcd_s%0d_c%0d", idx, c),
            8'(bcd), 8'(b));
      end
      tick();
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    enable   = 1'b0;
    lz_blank = 1'b0;
    score_a  = 8'h00;
    score_b  = 8'h00;
    #1 reset_n = 1'b0;
    #1 chk_idle("reset");
    repeat (3) @(negedge clk);
    chk_idle("reset_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle("idle");
    end

    // Normal scan, then tear-free update mid-frame.
    score_a = 8'h47;
    score_b = 8'h12;
    enable  = 1'b1;
    tick();
    slot(2'd0, 4'b0111, 4'd4, 1'b0);
    slot(2'd1, 4'b1011, 4'd7, 1'b0);
    slot(2'd2, 4'b1101, 4'd1, 1'b0);
    slot(2'd3, 4'b1110, 4'd2, 1'b0);
    slot(2'd0, 4'b0111, 4'd4, 1'b1);
    score_a = 8'h99;
    slot(2'd1, 4'b1011, 4'd7, 1'b0);
    slot(2'd2, 4'b1101, 4'd1, 1'b0);
    slot(2'd3, 4'b1110, 4'd2, 1'b0);
    slot(2'd0, 4'b0111, 4'd9, 1'b1);
    slot(2'd1, 4'b1011, 4'd9, 1'b0);
    slot(2'd2, 4'b1101, 4'd1, 1'b0);
    slot(2'd3, 4'b1110, 4'd2, 1'b0);

    // Leading-zero suppression via restart.
    enable = 1'b0;
    tick();
    chk_idle("dis1");
    score_a  = 8'h05;
    score_b  = 8'h30;
    lz_blank = 1'b1;
    enable   = 1'b1;
    tick();
    slot(2'd0, 4'b1111, 4'hF, 1'b0);
    slot(2'd1, 4'b1011, 4'd5, 1'b0);
    slot(2'd2, 4'b1101, 4'd3, 1'b0);
    slot(2'd3, 4'b1110, 4'd0, 1'b0);
    lz_blank = 1'b0;
    slot(2'd0, 4'b0111, 4'd0, 1'b1);
    score_b = 8'hA3;
    slot(2'd1, 4'b1011, 4'd5, 1'b0);
    slot(2'd2, 4'b1101, 4'd3, 1'b0);
    slot(2'd3, 4'b1110, 4'd0, 1'b0);
    // Invalid tens nibble keeps its anode lit.
    slot(2'd0, 4'b0111, 4'd0, 1'b1);
    slot(2'd1, 4'b1011, 4'd5, 1'b0);
    slot(2'd2, 4'b1101, 4'hF, 1'b0);
    slot(2'd3, 4'b1110, 4'd3, 1'b0);

    // Disable during the idx2 ON phase.
    slot(2'd0, 4'b0111, 4'd0, 1'b1);
    slot(2'd1, 4'b1011, 4'd5, 1'b0);
    tick();
    tick();
    chk("mid_anodo", 8'(anodo), 8'h0D);
    chk("mid_idx", 8'(digit_idx), 8'h2);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_idle("dis2");
    end
    enable = 1'b1;
    tick();
    slot(2'd0, 4'b0111, 4'd0, 1'b0);
    slot(2'd1, 4'b1011, 4'd5, 1'b0);

    // Asynchronous reset between edges during idx2 ON.
    tick();
    tick();
    chk("pre_rst_anodo", 8'(anodo), 8'h0D);
    chk("pre_rst_bcd", 8'(bcd), 8'hF);
    #1 reset_n = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("rst_held");
    reset_n = 1'b1;
    enable  = 1'b0;
    tick();
    chk_idle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
